// File: rtl/riscv_ifu_pkg.sv
// riscv_ifu_pkg: shared types and AXI constants for the instruction fetch unit
package riscv_ifu_pkg;
  localparam int PC_W = 32;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [2:0] ARSIZE_WORD = 3'b010;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     data;
    logic            fault;
  } fetch_entry_t;
endpackage

// File: rtl/riscv_ifu_fifo.sv
// riscv_ifu_fifo: synchronous first-word-fall-through FIFO with flush
module riscv_ifu_fifo #(
  parameter type T = logic,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  T mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    do_push = push && cnt_q != CW'(DEPTH);
    do_pop = pop && cnt_q != '0;
    wr_d = flush ? '0 : do_push ? inc(wr_q) : wr_q;
    rd_d = flush ? '0 : do_pop ? inc(rd_q) : rd_q;
    cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end
  assign dout = mem_q[rd_q];
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/riscv_ifu_fetch.sv
// riscv_ifu_fetch: sequential-PC AXI4 instruction prefetcher with redirect and stale-response drop
module riscv_ifu_fetch
  import riscv_ifu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h200,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [31:0]       RDATA,
  input  logic [1:0]        RRESP,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [31:0]       instr_data,
  output logic              instr_fault
);
  localparam int CW = $clog2(BUF_DEPTH+1);
  localparam int SW = CW + 1;
  logic [ADDR_W-1:0] pc_q, pc_d, araddr_q, araddr_d, pc_sel, pcq_head;
  logic arvalid_q, arvalid_d;
  logic [CW-1:0] drop_q, drop_d, out_cnt, out_d, buf_cnt, buf_d;
  logic [$clog2(MAX_OUTSTANDING+1)-1:0] pcq_cnt;
  logic pcq_empty, buf_empty, ar_fire, r_fire, hold, issue, new_req, push_buf, pop_buf;
  fetch_entry_t new_e, head;
  always_comb begin
    ar_fire = arvalid_q && ARREADY;
    r_fire = RVALID && !pcq_empty;
    hold = arvalid_q && !ARREADY;
    push_buf = r_fire && drop_q == '0;
    pop_buf = !buf_empty && instr_ready;
    out_cnt = CW'(pcq_cnt);
    out_d = out_cnt + CW'(ar_fire) - CW'(r_fire);
    buf_d = redirect ? '0 : buf_cnt + CW'(push_buf) - CW'(pop_buf);
    pc_sel = redirect ? (redirect_pc & ~ADDR_W'(3)) : pc_q;
    // credit on post-update counts so every in-flight beat is guaranteed a buffer slot
    issue = fetch_en && ({1'b0, out_d} + {1'b0, buf_d} < SW'(BUF_DEPTH))
            && out_d < CW'(MAX_OUTSTANDING);
    arvalid_d = hold || issue;
    new_req = !hold && issue;
    araddr_d = new_req ? pc_sel : araddr_q;
    pc_d = new_req ? pc_sel + ADDR_W'(4) : pc_sel;
    // a held AR belongs to the old stream: its beat is dropped once it is taken
    drop_d = redirect ? out_d + CW'(hold) : drop_q - CW'(r_fire && drop_q != '0);
    new_e.pc = PC_W'(pcq_head);
    new_e.data = RDATA;
    new_e.fault = RRESP != RESP_OKAY;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
      araddr_q <= RESET_PC;
      arvalid_q <= 1'b0;
      drop_q <= '0;
    end else begin
      pc_q <= pc_d;
      araddr_q <= araddr_d;
      arvalid_q <= arvalid_d;
      drop_q <= drop_d;
    end
  end
  riscv_ifu_fifo #(.T(logic [ADDR_W-1:0]), .DEPTH(MAX_OUTSTANDING)) u_pcq (
    .clock(clock),
    .reset(reset),
    .flush(1'b0),
    .push(ar_fire),
    .din(araddr_q),
    .pop(r_fire),
    .dout(pcq_head),
    .empty(pcq_empty),
    .count(pcq_cnt)
  );
  riscv_ifu_fifo #(.T(fetch_entry_t), .DEPTH(BUF_DEPTH)) u_buf (
    .clock(clock),
    .reset(reset),
    .flush(redirect),
    .push(push_buf),
    .din(new_e),
    .pop(pop_buf),
    .dout(head),
    .empty(buf_empty),
    .count(buf_cnt)
  );
  assign ARVALID = arvalid_q;
  assign ARADDR = araddr_q;
  assign ARLEN = 8'd0;
  assign ARSIZE = ARSIZE_WORD;
  assign RREADY = !pcq_empty;
  assign instr_valid = !buf_empty;
  assign instr_pc = ADDR_W'(head.pc);
  assign instr_data = head.data;
  assign instr_fault = head.fault;
endmodule

// File: tb/tb_riscv_ifu_fetch.sv
// tb_riscv_ifu_fetch: directed table, corner sequences and random traffic against a stream-level model
module tb_riscv_ifu_fetch;
  logic clock = 0, reset = 1, fetch_en = 0, redirect = 0, ARREADY = 0, RVALID = 0, instr_ready = 0;
  logic [31:0] redirect_pc = 0, RDATA = 0, ARADDR, instr_pc, instr_data;
  logic [1:0] RRESP = 0;
  logic ARVALID, RREADY, instr_valid, instr_fault;
  logic [7:0] ARLEN;
  logic [2:0] ARSIZE;

  riscv_ifu_fetch dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en), .redirect(redirect), .redirect_pc(redirect_pc),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_pc(instr_pc),
    .instr_data(instr_data), .instr_fault(instr_fault)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_fail = 0, n_ar = 0, n_instr = 0, n_fault = 0, outst = 0, r_pct = 100;
  logic [31:0] exp_pc, exp_ar, redir_tgt, prev_addr, last_pc, fault_addr = 32'h1;
  bit redir_pend, prev_hold, saw_wrap, fault_any, r_hold;
  logic [31:0] slave_q[$], ar_log[$];

  typedef struct {
    int n;
    bit fen, arr, ir;
    int ars;
    bit arv, iv;
  } vec_t;
  vec_t tbl[3];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_3C5A;
  endfunction

  function automatic bit is_fault(input logic [31:0] a);
    return a == fault_addr || (fault_any && a[4:2] == 3'd5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one cycle: drive inputs at negedge, then predict the handshakes of the coming edge
  task automatic step(input bit fen, input bit arr, input bit ir, input bit rd, input logic [31:0] rpc);
    bit rv;
    @(negedge clock);
    if (!reset && prev_hold) begin
      chk("ar_hold_valid", ARVALID, 1);
      chk("ar_hold_addr", ARADDR, prev_addr);
    end
    fetch_en = fen; ARREADY = arr; instr_ready = ir; redirect = rd; redirect_pc = rpc;
    rv = slave_q.size() > 0 && !r_hold && $urandom_range(99) < r_pct;
    RVALID = rv;
    if (rv) begin
      RDATA = word_of(slave_q[0]);
      RRESP = is_fault(slave_q[0]) ? 2'b10 : 2'b00;
    end else begin
      RDATA = $urandom;
      RRESP = 2'($urandom);
    end
    if (reset) return;
    chk("rready", RREADY, outst != 0);
    chk("credit", outst <= 4, 1);
    if (instr_valid && ir) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr_data", instr_data, word_of(exp_pc));
      chk("instr_fault", instr_fault, is_fault(exp_pc));
      if (last_pc == 32'hFFFF_FFFC && instr_pc == 0) saw_wrap = 1;
      last_pc = instr_pc;
      n_fault += int'(instr_fault);
      exp_pc += 4;
      n_instr++;
    end
    if (ARVALID && arr) begin
      chk("ar_addr", ARADDR, exp_ar);
      slave_q.push_back(ARADDR);
      ar_log.push_back(ARADDR);
      outst++;
      n_ar++;
      exp_ar = redir_pend ? redir_tgt : exp_ar + 4;
      redir_pend = 0;
    end
    if (rv && RREADY) begin
      void'(slave_q.pop_front());
      outst--;
    end
    if (rd) begin
      exp_pc = rpc & ~32'd3;
      if (ARVALID && !arr) begin
        redir_pend = 1;
        redir_tgt = exp_pc;
      end else begin
        exp_ar = exp_pc;
        redir_pend = 0;
      end
    end
    prev_hold = ARVALID && !arr;
    prev_addr = ARADDR;
  endtask

  task automatic do_reset();
    reset = 1;
    slave_q.delete();
    ar_log.delete();
    outst = 0;
    step(0, 0, 0, 1, 32'h5550);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clock);
    chk("reset_arvalid", ARVALID, 0);
    chk("reset_rready", RREADY, 0);
    chk("reset_instr_valid", instr_valid, 0);
    exp_pc = 32'h200; exp_ar = 32'h200; last_pc = 0;
    redir_pend = 0; prev_hold = 0; saw_wrap = 0;
    reset = 0;
  endtask

  initial begin
    int base;
    tbl[0] = '{12, 1, 1, 0, 4, 0, 1};
    tbl[1] = '{12, 1, 1, 1, 11, 1, 1};
    tbl[2] = '{10, 0, 1, 1, 1, 0, 0};
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0);
      chk("stall_arvalid", ARVALID, 1);
      chk("stall_araddr", ARADDR, 32'h200);
    end
    for (int i = 0; i < 3; i++) begin
      base = n_ar;
      repeat (tbl[i].n) step(tbl[i].fen, tbl[i].arr, tbl[i].ir, 0, 0);
      @(posedge clock);
      #1;
      chk("tbl_ar_count", n_ar - base, tbl[i].ars);
      chk("tbl_arvalid", ARVALID, tbl[i].arv);
      chk("tbl_instr_valid", instr_valid, tbl[i].iv);
    end

    do_reset();
    repeat (10) step(1, 1, 1, 0, 0);
    base = n_instr;
    repeat (20) step(1, 1, 1, 0, 0);
    chk("no_gap", n_instr - base, 20);

    do_reset();
    r_hold = 1;
    base = n_ar;
    repeat (3) step(1, 1, 1, 0, 0);
    repeat (2) step(0, 1, 1, 0, 0);
    chk("inflight", n_ar - base, 3);
    r_hold = 0;
    step(1, 1, 0, 1, 32'h1000);
    for (int t = 0; t < 40 && !instr_valid; t++) step(1, 1, 0, 0, 0);
    chk("redir_valid", instr_valid, 1);
    chk("redir_first_pc", instr_pc, 32'h1000);
    repeat (10) step(1, 1, 1, 0, 0);

    do_reset();
    repeat (4) step(1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 1, 32'h1000);
    repeat (2) step(1, 1, 1, 0, 0);
    chk("held_old_addr", ar_log[ar_log.size()-2], 32'h20C);
    chk("held_new_addr", ar_log[ar_log.size()-1], 32'h1000);
    for (int t = 0; t < 40 && !instr_valid; t++) step(1, 1, 0, 0, 0);
    chk("held_first_pc", instr_pc, 32'h1000);
    repeat (10) step(1, 1, 1, 0, 0);

    do_reset();
    fault_addr = 32'h204;
    n_fault = 0;
    repeat (20) step(1, 1, 1, 0, 0);
    chk("fault_count", n_fault, 1);
    fault_addr = 32'h1;

    do_reset();
    step(1, 1, 1, 1, 32'hFFFF_FFFB);
    repeat (15) step(1, 1, 1, 0, 0);
    chk("wrap", saw_wrap, 1);

    do_reset();
    fault_any = 1;
    r_pct = 60;
    base = n_instr;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(9) != 0, $urandom_range(9) < 7, $urandom_range(9) < 7,
           $urandom_range(99) < 3, $urandom);
    r_pct = 100;
    repeat (40) step(0, 1, 1, 0, 0);
    chk("drain_outstanding", outst, 0);
    chk("drain_arvalid", ARVALID, 0);
    chk("drain_instr_valid", instr_valid, 0);
    chk("random_progress", n_instr - base > 500, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_fail);
    $fatal(1);
  end
endmodule
